hd_serial_rx: RTL and testbench
===============================

# hd_serial_rx

Serial front-end for the two-codeword Hamming decoder stage. It deserialises a 1-bit input stream into a frame holding two 7-bit Hamming codewords, and flags which codewords carry a nonzero syndrome. It then presents the pair to the downstream decoder through a valid/ready output register. It also handles stalled or aborted frames and back-pressure overflow.

## Interface
- TIMEOUT, 4, number of consecutive idle cycles (in_valid low) mid-frame after which the partial frame is discarded; legal range 1-15.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit.
- out_ready  in  1  downstream accepts the frame when out_valid is also high.
- out_valid  out  1  code_word1/code_word2/err_flag hold a complete frame.
- code_word1  out  7  first codeword; bit 6..4 = p1..p3, bit 3..0 = x1..x4.
- code_word2  out  7  second codeword; same bit layout.
- err_flag  out  2  [1] = syndrome of code_word1 nonzero, [0] = syndrome of code_word2 nonzero.
- timeout_err  out  1  one-cycle pulse when a partial frame is discarded on timeout.
- overflow  out  1  sticky; set when a completed frame is dropped because the output register is full.

## Operation
- **Frame format:** 14 valid bits, MSB first.
  - Accepted bits 1-7 are code_word1[6] down to code_word1[0].
  - Accepted bits 8-14 are code_word2[6] down to code_word2[0].
  - Gaps (in_valid low) are allowed between bits.
- **Receive state** (4-bit bit counter, 14-bit shift register, idle counter).
  - **IDLE:** bit_cnt = 0. An in_valid bit moves the FSM to RECV with bit_cnt = 1.
  - **RECV:**
    - Each in_valid bit shifts in, increments bit_cnt and clears idle_cnt.
    - Each cycle with in_valid low increments idle_cnt.
    - When idle_cnt reaches TIMEOUT: go to IDLE, discard the partial frame and pulse timeout_err.
    - On the 14th bit: the frame completes, the FSM returns to IDLE and bit_cnt is 0.
    - A bit arriving in the cycle after completion starts a new frame; back-to-back frames need no gap.
- **Syndrome**, per word w with bits b6..b0:
  - s1 = b6^b3^b2^b1
  - s2 = b5^b3^b2^b0
  - s3 = b4^b3^b1^b0
  - err flag = s1|s2|s3.
  - Computed combinationally from the completed frame and registered together with the codewords.
- **Output register:**
  - Frame completes while out_valid = 0, or while out_valid & out_ready (accepted on the same edge): load the frame and set out_valid = 1.
  - Frame completes while out_valid = 1 and out_ready = 0: drop the new frame, keep the held frame, set overflow.
  - out_valid & out_ready with no new frame: out_valid goes to 0. The data outputs keep their last value.
  - Held data never changes while out_valid = 1 and out_ready = 0.
- **overflow** clears only on reset.

## Timing
- **Reset values:**
  - out_valid = 0, code_word1 = 0, code_word2 = 0, err_flag = 0, timeout_err = 0, overflow = 0.
  - FSM = IDLE, bit_cnt = 0, idle_cnt = 0.
- **Reset mid-frame or mid-hold:** all state clears immediately (asynchronous). The partial or held frame is lost, and no timeout_err pulse is produced.
- **Latency:** the 14th bit is sampled at edge N; out_valid = 1 with the frame from edge N (visible in cycle N+1).
- **Handshake:** a transfer occurs on the edge where out_valid & out_ready = 1. out_ready may be high while out_valid = 0 with no effect.
- **Timeout:**
  - Applies only in RECV.
  - With TIMEOUT = 4, the 4th consecutive idle cycle sets FSM = IDLE at that edge, and timeout_err is high for exactly the following cycle.
  - A bit arriving on the edge that would hit the timeout is accepted and cancels the timeout.
- **Simultaneous completion and acceptance:** the new frame replaces the old one and out_valid stays 1; overflow is not set.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Test plan
- **Clean frame, no gaps.** Reset, then 14 bits: 0x1B (0011011) followed by 0x00. Required: out_valid rises one cycle after the 14th bit, code_word1 = 0x1B, code_word2 = 0x00, err_flag = 2'b00.
- **Single-bit error with gaps.** Send 0x1A then 0x1B with random in_valid gaps shorter than TIMEOUT. Required: code_word1 = 0x1A, code_word2 = 0x1B, err_flag = 2'b10.
- **Timeout.** TIMEOUT = 4, send 5 bits then hold in_valid low for 4 cycles. Required: timeout_err pulses once and no out_valid. A following clean 14-bit frame of 0x7F/0x7F is then received correctly, with err_flag = 2'b00.
- **Back-pressure overflow.** Hold out_ready = 0 and send two back-to-back frames (0x1B/0x1B, then 0x00/0x00). Required: the output stays at 0x1B/0x1B and overflow = 1. After raising out_ready for one cycle, out_valid = 0.
- **Simultaneous accept and completion.** out_ready pulses high exactly on the edge the second frame completes. Required: the second frame is loaded, out_valid stays 1 and overflow stays 0.
- **Reset mid-frame.** Assert rst_n low after 9 bits. Required: outputs reset immediately. A new full frame afterwards is received correctly, with no stale bits.

Source files
------------

// File: rtl/hd_serial_rx_if.sv
// Serial-in / frame-out bundle for hd_serial_rx.
// slave: in_valid,in_bit,out_ready in; frame, flags out. master: reverse.
interface hd_serial_rx_if;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       out_valid;
  logic [6:0] code_word1;
  logic [6:0] code_word2;
  logic [1:0] err_flag;
  logic       timeout_err;
  logic       overflow;

  modport master (
    output in_valid, in_bit, out_ready,
    input  out_valid, code_word1, code_word2,
    input  err_flag, timeout_err, overflow
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output out_valid, code_word1, code_word2,
    output err_flag, timeout_err, overflow
  );
endinterface

// File: rtl/hd_serial_rx.sv
// Deserialises two 7-bit Hamming codewords, flags nonzero syndromes.
// Ports: clk, rst_n (async low), bus (slave: serial in, frame out).
module hd_serial_rx #(
  parameter int TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  hd_serial_rx_if.slave bus
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  idle_cnt_q;
  logic [13:0] shift_q;
  logic        out_valid_q;
  logic [6:0]  cw1_q;
  logic [6:0]  cw2_q;
  logic [1:0]  err_q;
  logic        tmo_q;
  logic        ovf_q;

  logic [13:0] frame_d;
  logic [1:0]  err_d;
  logic        done;

  function automatic logic syn_nz(input logic [6:0] w);
    logic s1, s2, s3;
    s1 = w[6] ^ w[3] ^ w[2] ^ w[1];
    s2 = w[5] ^ w[3] ^ w[2] ^ w[0];
    s3 = w[4] ^ w[3] ^ w[1] ^ w[0];
    return s1 | s2 | s3;
  endfunction

  always_comb begin
    frame_d = {shift_q[12:0], bus.in_bit};
    err_d   = {syn_nz(frame_d[13:7]),
               syn_nz(frame_d[6:0])};
    done    = (state_q == RECV) && bus.in_valid
           && (bit_cnt_q == 4'd13);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      cw1_q       <= '0;
      cw2_q       <= '0;
      err_q       <= '0;
      tmo_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q    <= RECV;
            bit_cnt_q  <= 4'd1;
            idle_cnt_q <= '0;
            shift_q    <= {13'b0, bus.in_bit};
          end
        end
        RECV: begin
          if (bus.in_valid) begin
            shift_q    <= frame_d;
            idle_cnt_q <= '0;
            if (done) begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (idle_cnt_q == 4'(TIMEOUT - 1)) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            tmo_q      <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A held frame that is not being taken blocks the new one.
      if (done) begin
        if (!out_valid_q || bus.out_ready) begin
          out_valid_q <= 1'b1;
          cw1_q       <= frame_d[13:7];
          cw2_q       <= frame_d[6:0];
          err_q       <= err_d;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.code_word1  = cw1_q;
  assign bus.code_word2  = cw2_q;
  assign bus.err_flag    = err_q;
  assign bus.timeout_err = tmo_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_hd_serial_rx.sv
// Scoreboard bench for hd_serial_rx: queue-based receive model,
// directed test-plan frames then randomized traffic.
module tb_hd_serial_rx;

  localparam int TMO = 4;

  typedef struct packed {
    logic [6:0] c1;
    logic [6:0] c2;
    logic [1:0] e;
  } frm_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hd_serial_rx_if bus ();

  hd_serial_rx #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  frm_t exp_q[$];
  bit   rx[$];
  int   idle = 0;
  bit   full = 0;
  bit   ovf = 0;
  bit   exp_to = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit bad(input logic [6:0] w);
    return (^(w & 7'b1001110)) | (^(w & 7'b0101101))
         | (^(w & 7'b0011011));
  endfunction

  // Reference: bits collect in a queue; 14 make a frame.
  task automatic model(input bit v, input bit b, input bit r);
    bit   fin;
    frm_t f;
    fin = 0;
    f = '0;
    exp_to = 0;
    if (v) begin
      rx.push_back(b);
      idle = 0;
      if (rx.size() == 14) begin
        for (int i = 0; i < 7; i++) begin
          f.c1[6-i] = rx[i];
          f.c2[6-i] = rx[7+i];
        end
        f.e = {bad(f.c1), bad(f.c2)};
        rx.delete();
        fin = 1;
      end
    end else if (rx.size() > 0) begin
      idle++;
      if (idle == TMO) begin
        rx.delete();
        idle = 0;
        exp_to = 1;
      end
    end
    if (fin) begin
      if (!full || r) begin
        exp_q.push_back(f);
        full = 1;
      end else begin
        ovf = 1;
      end
    end else if (full && r) begin
      full = 0;
    end
  endtask

  task automatic cyc(input bit v, input bit b, input bit r);
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.out_ready = r;
    @(posedge clk);
    model(v, b, r);
    #1;
  endtask

  task automatic send(input logic [6:0] w1, input logic [6:0] w2,
                      input int gap, input bit r, input bit lr);
    logic [13:0] fr;
    fr = {w1, w2};
    for (int i = 13; i >= 0; i--) begin
      if (gap > 0 && i != 13) begin
        int g;
        g = $urandom_range(gap, 0);
        for (int k = 0; k < g; k++) cyc(0, 0, r);
      end
      cyc(1, fr[i], (i == 0) ? lr : r);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid  = 0;
    bus.in_bit    = 0;
    bus.out_ready = 0;
    #1;
    chk("rst_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_cw", {2'b0, bus.code_word1, bus.code_word2}, 16'h0);
    chk("rst_err", 16'(bus.err_flag), 16'h0);
    chk("rst_flags", {14'b0, bus.timeout_err, bus.overflow}, 16'h0);
    rx.delete();
    exp_q.delete();
    idle = 0;
    full = 0;
    ovf = 0;
    exp_to = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: outputs are stable at the falling edge.
  initial begin
    frm_t f;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", 16'(bus.out_valid), 16'(full));
        chk("timeout_err", 16'(bus.timeout_err), 16'(exp_to));
        chk("overflow", 16'(bus.overflow), 16'(ovf));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 16'h1, 16'h0);
          end else begin
            f = exp_q.pop_front();
            chk("frame",
                {bus.code_word1, bus.code_word2, bus.err_flag},
                f);
          end
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 0;
    bus.in_bit    = 0;
    bus.out_ready = 0;
    #2;
    do_reset();

    // Clean frame, no gaps
    send(7'h1B, 7'h00, 0, 0, 0);
    chk("t1_valid", 16'(bus.out_valid), 16'h1);
    chk("t1_cw", {2'b0, bus.code_word1, bus.code_word2}, 16'h0D80);
    chk("t1_err", 16'(bus.err_flag), 16'h0);
    cyc(0, 0, 1);

    // Single-bit error with gaps
    send(7'h1A, 7'h1B, TMO - 1, 0, 0);
    chk("t2_cw", {2'b0, bus.code_word1, bus.code_word2}, 16'h0D1B);
    chk("t2_err", 16'(bus.err_flag), 16'h2);
    cyc(0, 0, 1);

    // Timeout
    for (int i = 0; i < 5; i++) cyc(1, 1, 1);
    for (int i = 0; i < TMO; i++) cyc(0, 0, 1);
    chk("t3_pulse", 16'(bus.timeout_err), 16'h1);
    chk("t3_novalid", 16'(bus.out_valid), 16'h0);
    cyc(0, 0, 1);
    chk("t3_pulse_end", 16'(bus.timeout_err), 16'h0);
    send(7'h7F, 7'h7F, 0, 0, 0);
    chk("t3_cw", {2'b0, bus.code_word1, bus.code_word2}, 16'h3FFF);
    chk("t3_err", 16'(bus.err_flag), 16'h0);
    cyc(0, 0, 1);

    // Back-pressure overflow
    do_reset();
    send(7'h1B, 7'h1B, 0, 0, 0);
    send(7'h00, 7'h00, 0, 0, 0);
    chk("t4_cw", {2'b0, bus.code_word1, bus.code_word2}, 16'h0D9B);
    chk("t4_ovf", 16'(bus.overflow), 16'h1);
    cyc(0, 0, 1);
    chk("t4_drained", 16'(bus.out_valid), 16'h0);

    // Simultaneous accept and completion
    do_reset();
    send(7'h1B, 7'h00, 0, 0, 0);
    send(7'h7F, 7'h7F, 0, 0, 1);
    chk("t5_cw", {2'b0, bus.code_word1, bus.code_word2}, 16'h3FFF);
    chk("t5_valid", 16'(bus.out_valid), 16'h1);
    chk("t5_ovf", 16'(bus.overflow), 16'h0);
    cyc(0, 0, 1);

    // Reset mid-frame
    for (int i = 0; i < 9; i++) cyc(1, 1, 0);
    do_reset();
    send(7'h1A, 7'h00, 0, 0, 0);
    chk("t6_cw", {2'b0, bus.code_word1, bus.code_word2}, 16'h0D00);
    chk("t6_err", 16'(bus.err_flag), 16'h2);
    cyc(0, 0, 1);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(99, 0) < 2) begin
        int g;
        g = $urandom_range(TMO + 1, 1);
        for (int k = 0; k < g; k++) cyc(0, 0, 1'($urandom));
      end else begin
        cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0);
      end
    end
    for (int k = 0; k < 2 * TMO; k++) cyc(0, 0, 1);
    chk("queue_empty", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
